d_sramlike_bridge: RTL

//  Data-side bus bridge directly downstream of the CPU datapath's MEM stage.

---
 rtl/d_sramlike_bridge_if.sv | 38 +++
 rtl/d_sramlike_bridge.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/d_sramlike_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : d_sramlike_bridge_if
//  Description : SRAM-like split-handshake data bus (request/addr_ok, then
//                data_ok). The bridge drives the request side through the
//                master modport. The memory slave answers through the slave
//                modport.
//  Signals     : data_req_o     request valid
//                data_wr_o      1 = write, 0 = read
//                data_size_o    0 = byte, 1 = half, 2 = word
//                data_addr_o    physical byte address
//                data_wdata_o   lane-aligned write data
//                data_addr_ok_i slave accepted the request this cycle
//                data_data_ok_i read data valid / write done this cycle
//                data_rdata_i   read data
//  Revision    : 1.0 - initial release
// ============================================================================
interface d_sramlike_bridge_if;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/d_sramlike_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : d_sramlike_bridge
//  Description : Bridge between the MEM stage of the CPU datapath and an
//                SRAM-like data bus. It turns a single-cycle load or store into
//                a request/addr_ok/data_ok transaction. It stalls the pipeline
//                while the transaction is in flight. It holds load data until
//                the whole pipeline releases the stall.
//  Parameters  : MAP_KSEG  non-zero maps kseg0/kseg1 to physical addresses
//  Ports       : clk              core clock
//                rst              asynchronous active-low reset
//                data_en_i        MEM-stage load/store valid
//                data_wen_i       byte write enables; any bit set = store
//                data_size_i      0 = byte, 1 = half, 2 = word
//                data_addr_i      virtual byte address
//                data_wdata_i     lane-aligned store data
//                flush_i          exception flush of the MEM stage
//                longest_stall_i  OR of all pipeline stall sources
//                d_stall_o        stall request to the hazard unit
//                data_rdata_o     captured load data
//                bus              SRAM-like bus, master side
//  Revision    : 1.0 - initial release
// ============================================================================
module d_sramlike_bridge #(
    parameter int MAP_KSEG = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             data_en_i,
    input  wire logic [3:0]       data_wen_i,
    input  wire logic [1:0]       data_size_i,
    input  wire logic [31:0]      data_addr_i,
    input  wire logic [31:0]      data_wdata_i,
    input  wire logic             flush_i,
    input  wire logic             longest_stall_i,
    output logic                  d_stall_o,
    output logic [31:0]           data_rdata_o,
    d_sramlike_bridge_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        start;
    logic        latch;
    logic        capture;
    logic [31:0] phys_addr;

    // The IDLE-cycle request path is combinational. Gating it with the reset
    // keeps the bus quiet while the reset is held.
    assign start = rst & data_en_i & ~flush_i;

    // kseg0 (100) and kseg1 (101) both have addr[31:30] == 2'b10.
    always_comb begin
        phys_addr = data_addr_i;
        if ((MAP_KSEG != 0) && (data_addr_i[31:30] == 2'b10)) begin
            phys_addr = {3'b000, data_addr_i[28:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (latch) begin
                wr_q    <= |data_wen_i;
                size_q  <= data_size_i;
                addr_q  <= phys_addr;
                wdata_q <= data_wdata_i;
            end
            if (capture) begin
                rdata_q <= bus.data_rdata_i;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        discard_d        = discard_q;
        latch            = 1'b0;
        capture          = 1'b0;
        d_stall_o        = 1'b0;
        bus.data_req_o   = 1'b0;
        bus.data_wr_o    = wr_q;
        bus.data_size_o  = size_q;
        bus.data_addr_o  = addr_q;
        bus.data_wdata_o = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Drive straight from the inputs so the request goes out
                    // in the same cycle the access appears.
                    latch            = 1'b1;
                    d_stall_o        = 1'b1;
                    bus.data_req_o   = 1'b1;
                    bus.data_wr_o    = |data_wen_i;
                    bus.data_size_o  = data_size_i;
                    bus.data_addr_o  = phys_addr;
                    bus.data_wdata_o = data_wdata_i;
                    state_d          = bus.data_addr_ok_i ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // A request cannot be withdrawn. A flush only marks the
                // result to be dropped.
                d_stall_o      = 1'b1;
                bus.data_req_o = 1'b1;
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (bus.data_addr_ok_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                d_stall_o = 1'b1;
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (bus.data_data_ok_i) begin
                    discard_d = 1'b0;
                    // A flush landing on the data_ok cycle also drops the result.
                    if (discard_q | flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        capture = ~wr_q;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // data_en_i is still high for the same instruction, so no
                // reissue happens here. Leave only when the pipeline moves.
                if (!longest_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_rdata_o = rdata_q;

endmodule
`default_nettype wire
